// File: rtl/neuron_tanh_linear_if.sv
// Parameter-fill and compute handshake bundle for neuron_tanh_linear.
// master drives requests and samples; slave is the neuron.
interface neuron_tanh_linear_if #(
    parameter int N_IN = 4,
    parameter int W    = 16,
    parameter int AW   = $clog2(N_IN + 1)
);
    logic                fill;
    logic [AW-1:0]       fill_addr;
    logic signed [W-1:0] fill_data;
    logic                ack_fill;
    logic                req;
    logic signed [W-1:0] x_in;
    logic [AW-1:0]       x_idx;
    logic signed [W-1:0] y_out;
    logic                ack_network;

    modport master (
        output fill, fill_addr, fill_data, req, x_in,
        input  ack_fill, x_idx, y_out, ack_network
    );

    modport slave (
        input  fill, fill_addr, fill_data, req, x_in,
        output ack_fill, x_idx, y_out, ack_network
    );
endinterface

// File: rtl/neuron_tanh_linear.sv
// Serial MAC neuron: N_IN weighted inputs plus bias, then activation.
// NEURON_TANH_LINEAR_HARDTANH_EN selects hard tanh; default is saturating linear.
module neuron_tanh_linear #(
    parameter int N_IN = 4,
    parameter int W    = 16,
    parameter int FRAC = 8,
    parameter int AW   = $clog2(N_IN + 1)
) (
    input logic               clk,
    input logic               rst,
    neuron_tanh_linear_if.slave bus
);
    localparam int PW   = 2 * W;
    localparam int ACCW = 2 * W + 8;
    localparam logic [AW-1:0] BIAS_A = AW'(N_IN);
    localparam logic [AW-1:0] LAST_A = AW'(N_IN - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_BIAS, S_ACT} state_t;

    state_t                 r_state;
    logic signed [W-1:0]    r_w [N_IN+1];
    logic signed [ACCW-1:0] r_acc;
    logic [AW-1:0]          r_idx;
    logic signed [W-1:0]    r_y;
    logic                   r_ack_fill;
    logic                   r_ack_net;

    logic signed [PW-1:0]   w_prod;
    logic signed [ACCW-1:0] w_prod_ext;
    logic signed [ACCW-1:0] w_bias_ext;
    logic signed [ACCW-1:0] w_shift;
    logic signed [W-1:0]    w_act;

    assign w_prod     = PW'(bus.x_in) * PW'(r_w[r_idx]);
    assign w_prod_ext = ACCW'(w_prod);
    assign w_bias_ext = ACCW'(r_w[N_IN]) <<< FRAC;
    assign w_shift    = r_acc >>> FRAC;

`ifdef NEURON_TANH_LINEAR_HARDTANH_EN
    localparam logic signed [ACCW-1:0] ONE  = ACCW'(1) <<< FRAC;
    localparam logic signed [ACCW-1:0] NONE = -ONE;

    always_comb begin
        w_act = w_shift[W-1:0];
        if (w_shift > ONE)
            w_act = ONE[W-1:0];
        else if (w_shift < NONE)
            w_act = NONE[W-1:0];
    end
`else
    localparam logic signed [ACCW-1:0] SAT_HI =
        {{(W+9){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [ACCW-1:0] SAT_LO =
        {{(W+9){1'b1}}, {(W-1){1'b0}}};

    always_comb begin
        w_act = w_shift[W-1:0];
        if (w_shift > SAT_HI)
            w_act = SAT_HI[W-1:0];
        else if (w_shift < SAT_LO)
            w_act = SAT_LO[W-1:0];
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_acc      <= '0;
            r_idx      <= '0;
            r_y        <= '0;
            r_ack_fill <= 1'b0;
            r_ack_net  <= 1'b0;
            for (int i = 0; i <= N_IN; i++)
                r_w[i] <= '0;
        end else begin
            r_ack_fill <= 1'b0;
            r_ack_net  <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    // A fill strobe blocks a start, even if its address is dropped
                    if (bus.fill) begin
                        if (bus.fill_addr <= BIAS_A) begin
                            r_w[bus.fill_addr] <= bus.fill_data;
                            r_ack_fill         <= 1'b1;
                        end
                    end else if (bus.req) begin
                        r_acc   <= '0;
                        r_idx   <= '0;
                        r_state <= S_ACC;
                    end
                end
                S_ACC: begin
                    r_acc <= r_acc + w_prod_ext;
                    if (r_idx == LAST_A) begin
                        r_idx   <= '0;
                        r_state <= S_BIAS;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_BIAS: begin
                    r_acc   <= r_acc + w_bias_ext;
                    r_state <= S_ACT;
                end
                S_ACT: begin
                    r_y       <= w_act;
                    r_ack_net <= 1'b1;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.ack_fill    = r_ack_fill;
    assign bus.x_idx       = r_idx;
    assign bus.y_out       = r_y;
    assign bus.ack_network = r_ack_net;
endmodule

// File: tb/tb_neuron_tanh_linear.sv
// Directed bench for neuron_tanh_linear: vector table plus corner sequences.
// Expected values follow NEURON_TANH_LINEAR_HARDTANH_EN when defined.
module tb_neuron_tanh_linear;
    localparam int N    = 4;
    localparam int W    = 16;
    localparam int FRAC = 8;
    localparam int AW   = 3;

    typedef struct {
        logic signed [W-1:0] w [N];
        logic signed [W-1:0] b;
        logic signed [W-1:0] x [N];
        int                  y_lin;
        int                  y_ht;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    logic signed [W-1:0] xs [8];
    vec_t vt [7];

    neuron_tanh_linear_if #(.N_IN(N), .W(W), .AW(AW)) bus ();

    neuron_tanh_linear #(
        .N_IN(N), .W(W), .FRAC(FRAC), .AW(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    assign bus.x_in = xs[bus.x_idx];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
        end
    endtask

    task automatic put(input logic [AW-1:0] a, input logic signed [W-1:0] d,
                       input logic exp_ack, input string nm);
        @(negedge clk);
        bus.fill      = 1'b1;
        bus.fill_addr = a;
        bus.fill_data = d;
        @(negedge clk);
        bus.fill = 1'b0;
        chk(nm, longint'(bus.ack_fill), longint'(exp_ack));
    endtask

    task automatic compute(input longint exp, input string nm);
        int j;
        @(negedge clk);
        bus.req = 1'b1;
        @(negedge clk);
        bus.req = 1'b0;
        j = 0;
        while (!bus.ack_network && j < 20) begin
            @(negedge clk);
            j++;
        end
        chk({nm, "_lat"}, j, 6);
        chk({nm, "_y"}, longint'($signed(bus.y_out)), exp);
    endtask

    task automatic quiet(input int n, input string nm);
        int c;
        c = 0;
        repeat (n) begin
            @(negedge clk);
            if (bus.ack_network) c++;
        end
        chk(nm, c, 0);
    endtask

    task automatic load(input logic signed [W-1:0] wv, input logic signed [W-1:0] bv,
                        input logic signed [W-1:0] xv);
        for (int k = 0; k < N; k++) begin
            put(AW'(k), wv, 1'b1, "fill_w");
            xs[k] = xv;
        end
        put(AW'(N), bv, 1'b1, "fill_b");
    endtask

    function automatic longint exp_y(input vec_t v);
`ifdef NEURON_TANH_LINEAR_HARDTANH_EN
        return longint'(v.y_ht);
`else
        return longint'(v.y_lin);
`endif
    endfunction

    initial begin
        int j;
        vt[0] = '{w: '{256, 256, 256, 256}, b: 0, x: '{64, 64, 64, 64},
                  y_lin: 256, y_ht: 256};
        vt[1] = '{w: '{256, 256, 256, 256}, b: 0, x: '{256, 256, 256, 256},
                  y_lin: 1024, y_ht: 256};
        vt[2] = '{w: '{-256, -256, -256, -256}, b: -128,
                  x: '{256, 256, 256, 256}, y_lin: -1152, y_ht: -256};
        vt[3] = '{w: '{32767, 32767, 32767, 32767}, b: 0,
                  x: '{32767, 32767, 32767, 32767}, y_lin: 32767, y_ht: 256};
        vt[4] = '{w: '{-32768, -32768, -32768, -32768}, b: 0,
                  x: '{32767, 32767, 32767, 32767}, y_lin: -32768, y_ht: -256};
        vt[5] = '{w: '{256, 512, -256, 128}, b: -1,
                  x: '{256, 128, 64, -513}, y_lin: 190, y_ht: 190};
        vt[6] = '{w: '{1, 0, 0, 0}, b: 0, x: '{-1, 0, 0, 0},
                  y_lin: -1, y_ht: -1};

        for (int k = 0; k < 8; k++) xs[k] = '0;
        rst           = 1'b1;
        bus.fill      = 1'b0;
        bus.fill_addr = '0;
        bus.fill_data = '0;
        bus.req       = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_y", longint'($signed(bus.y_out)), 0);
        chk("rst_ack_net", longint'(bus.ack_network), 0);
        chk("rst_ack_fill", longint'(bus.ack_fill), 0);
        chk("rst_x_idx", longint'(bus.x_idx), 0);
        for (int k = 0; k < N; k++) xs[k] = 100;
        compute(0, "rst_weights");

        for (int i = 0; i < 7; i++) begin
            for (int k = 0; k < N; k++) begin
                put(AW'(k), vt[i].w[k], 1'b1, $sformatf("v%0d_fill_w%0d", i, k));
                xs[k] = vt[i].x[k];
            end
            put(AW'(N), vt[i].b, 1'b1, $sformatf("v%0d_fill_b", i));
            compute(exp_y(vt[i]), $sformatf("v%0d", i));
        end

        // Reset during the second ACC cycle aborts the request
        load(256, 0, 64);
        @(negedge clk);
        bus.req = 1'b1;
        @(negedge clk);
        bus.req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        quiet(10, "abort_noack");
        chk("abort_y", longint'($signed(bus.y_out)), 0);
        compute(0, "abort_weights");

        // Fill during ACC and out-of-range fill are both dropped
        load(256, 0, 64);
        @(negedge clk);
        bus.req = 1'b1;
        @(negedge clk);
        bus.req       = 1'b0;
        bus.fill      = 1'b1;
        bus.fill_addr = 3'd2;
        bus.fill_data = 512;
        @(negedge clk);
        bus.fill = 1'b0;
        chk("fill_in_acc", longint'(bus.ack_fill), 0);
        j = 1;
        while (!bus.ack_network && j < 20) begin
            @(negedge clk);
            j++;
        end
        chk("fill_in_acc_y", longint'($signed(bus.y_out)), 256);
        put(3'd7, 512, 1'b0, "fill_oob");
        compute(256, "w2_kept");

        // Fill and req together: fill wins, no compute starts
        @(negedge clk);
        bus.fill      = 1'b1;
        bus.fill_addr = 3'd0;
        bus.fill_data = 256;
        bus.req       = 1'b1;
        @(negedge clk);
        bus.fill = 1'b0;
        bus.req  = 1'b0;
        chk("fill_req_ack", longint'(bus.ack_fill), 1);
        quiet(10, "fill_wins");

        // req held high: back-to-back results 7 cycles apart
        load(0, 128, 77);
        @(negedge clk);
        bus.req = 1'b1;
        @(negedge clk);
        j = 0;
        while (!bus.ack_network && j < 20) begin
            @(negedge clk);
            j++;
        end
        chk("b2b_lat1", j, 6);
        chk("b2b_y1", longint'($signed(bus.y_out)), 128);
        @(negedge clk);
        j = 1;
        while (!bus.ack_network && j < 20) begin
            @(negedge clk);
            j++;
        end
        bus.req = 1'b0;
        chk("b2b_gap", j, 7);
        chk("b2b_y2", longint'($signed(bus.y_out)), 128);
        quiet(10, "b2b_stop");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
